serial_bridge: RTL and testbench

SERIAL_BRIDGE -- requirements
Module: serial_bridge

---
 rtl/serial_bridge_if.sv | 42 ++++
 rtl/serial_bridge.sv | 59 +++++
 tb/tb_serial_bridge.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/serial_bridge_if.sv
// serial_bridge_if: host and processor byte streams plus occupancy of the serial bridge.
// drop_count_out exists only when SERIAL_BRIDGE_DROP_CNT_EN is defined.
interface serial_bridge_if #(parameter int DEPTH = 8);
   localparam int CW = $clog2(DEPTH) + 1;
   logic [7:0] host_rx_data_in;
   logic host_rx_valid_in;
   logic host_rx_ready_out;
   logic [7:0] host_tx_data_out;
   logic host_tx_valid_out;
   logic host_tx_ready_in;
   logic [7:0] proc_rx_data_out;
   logic proc_rx_valid_out;
   logic proc_rx_rden_in;
   logic proc_tx_ready_out;
   logic [7:0] proc_tx_data_in;
   logic proc_tx_wren_in;
   logic [CW-1:0] rx_count_out;
   logic [CW-1:0] tx_count_out;
`ifdef SERIAL_BRIDGE_DROP_CNT_EN
   logic [7:0] drop_count_out;
`endif
   modport slave (
      input host_rx_data_in, host_rx_valid_in, host_tx_ready_in,
      input proc_rx_rden_in, proc_tx_data_in, proc_tx_wren_in,
      output host_rx_ready_out, host_tx_data_out, host_tx_valid_out,
      output proc_rx_data_out, proc_rx_valid_out, proc_tx_ready_out,
`ifdef SERIAL_BRIDGE_DROP_CNT_EN
      output drop_count_out,
`endif
      output rx_count_out, tx_count_out
   );
   modport master (
      output host_rx_data_in, host_rx_valid_in, host_tx_ready_in,
      output proc_rx_rden_in, proc_tx_data_in, proc_tx_wren_in,
      input host_rx_ready_out, host_tx_data_out, host_tx_valid_out,
      input proc_rx_data_out, proc_rx_valid_out, proc_tx_ready_out,
`ifdef SERIAL_BRIDGE_DROP_CNT_EN
      input drop_count_out,
`endif
      input rx_count_out, tx_count_out
   );
endinterface

// File: rtl/serial_bridge.sv
// serial_bridge: independent first-word-fall-through RX (host->proc) and TX (proc->host) byte FIFOs.
// Define SERIAL_BRIDGE_DROP_CNT_EN to add a saturating count of dropped writes / empty reads.
module serial_bridge #(parameter int DEPTH = 8) (
   input logic clock,
   input logic reset,
   serial_bridge_if.slave bus
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   logic [7:0] rx_mem [DEPTH];
   logic [7:0] tx_mem [DEPTH];
   logic [AW-1:0] rx_wp, rx_rp, tx_wp, tx_rp;
   logic [CW-1:0] rx_cnt, tx_cnt;
   logic rx_push, rx_pop, tx_push, tx_pop;
   assign bus.host_rx_ready_out = rx_cnt < CW'(DEPTH);
   assign bus.proc_rx_valid_out = rx_cnt != '0;
   assign bus.proc_tx_ready_out = tx_cnt < CW'(DEPTH);
   assign bus.host_tx_valid_out = tx_cnt != '0;
   assign bus.proc_rx_data_out = rx_mem[rx_rp];
   assign bus.host_tx_data_out = tx_mem[tx_rp];
   assign bus.rx_count_out = rx_cnt;
   assign bus.tx_count_out = tx_cnt;
   assign rx_push = bus.host_rx_valid_in && bus.host_rx_ready_out;
   assign rx_pop = bus.proc_rx_rden_in && bus.proc_rx_valid_out;
   assign tx_push = bus.proc_tx_wren_in && bus.proc_tx_ready_out;
   assign tx_pop = bus.host_tx_ready_in && bus.host_tx_valid_out;
   // Storage is not reset; outputs are qualified by the valids.
   always_ff @(posedge clock) begin
      if (rx_push) rx_mem[rx_wp] <= bus.host_rx_data_in;
      if (tx_push) tx_mem[tx_wp] <= bus.proc_tx_data_in;
   end
   // DEPTH is a power of two, so pointer increments wrap on their own.
   always_ff @(posedge clock) begin
      if (reset) begin
         rx_wp <= '0;
         rx_rp <= '0;
         rx_cnt <= '0;
         tx_wp <= '0;
         tx_rp <= '0;
         tx_cnt <= '0;
      end else begin
         rx_wp <= rx_wp + AW'(rx_push);
         rx_rp <= rx_rp + AW'(rx_pop);
         rx_cnt <= rx_cnt + CW'(rx_push) - CW'(rx_pop);
         tx_wp <= tx_wp + AW'(tx_push);
         tx_rp <= tx_rp + AW'(tx_pop);
         tx_cnt <= tx_cnt + CW'(tx_push) - CW'(tx_pop);
      end
   end
`ifdef SERIAL_BRIDGE_DROP_CNT_EN
   logic drop;
   assign drop = (bus.proc_tx_wren_in && !bus.proc_tx_ready_out) ||
                 (bus.proc_rx_rden_in && !bus.proc_rx_valid_out);
   always_ff @(posedge clock) begin
      if (reset) bus.drop_count_out <= '0;
      else if (drop && bus.drop_count_out != 8'hff) bus.drop_count_out <= bus.drop_count_out + 8'd1;
   end
`endif
endmodule

// File: tb/tb_serial_bridge.sv
// tb_serial_bridge: scoreboard bench for serial_bridge; expected bytes queue on push, compare on pop.
module tb_serial_bridge;
   localparam int DEPTH = 8;
   logic clock = 1'b0;
   logic reset = 1'b1;
   int n_checks = 0;
   int n_errors = 0;
   logic [7:0] rx_q[$];
   logic [7:0] tx_q[$];
   serial_bridge_if #(.DEPTH(DEPTH)) bus ();
   serial_bridge #(.DEPTH(DEPTH)) dut (.clock(clock), .reset(reset), .bus(bus));
   always #5 clock = ~clock;
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask
   task automatic step;
      @(posedge clock);
      #1;
   endtask
   task automatic drain_rx;
      int n = 0;
      while (rx_q.size() != 0 && n < 60) begin
         bus.proc_rx_rden_in = bus.proc_rx_valid_out;
         if (bus.proc_rx_valid_out) check("rx_data", 32'(bus.proc_rx_data_out), 32'(rx_q.pop_front()));
         step();
         n++;
      end
      bus.proc_rx_rden_in = 1'b0;
      check("rx_drain_left", rx_q.size(), 0);
      check("rx_valid_drained", 32'(bus.proc_rx_valid_out), 0);
   endtask
   task automatic drain_tx;
      int n = 0;
      bus.host_tx_ready_in = 1'b1;
      while (tx_q.size() != 0 && n < 60) begin
         if (bus.host_tx_valid_out) check("tx_data", 32'(bus.host_tx_data_out), 32'(tx_q.pop_front()));
         step();
         n++;
      end
      bus.host_tx_ready_in = 1'b0;
      check("tx_drain_left", tx_q.size(), 0);
      check("tx_valid_drained", 32'(bus.host_tx_valid_out), 0);
   endtask
   task automatic check_idle(input string tag);
      check({tag, "_rx_cnt"}, 32'(bus.rx_count_out), 0);
      check({tag, "_tx_cnt"}, 32'(bus.tx_count_out), 0);
      check({tag, "_rx_valid"}, 32'(bus.proc_rx_valid_out), 0);
      check({tag, "_tx_valid"}, 32'(bus.host_tx_valid_out), 0);
      check({tag, "_rx_ready"}, 32'(bus.host_rx_ready_out), 1);
      check({tag, "_tx_ready"}, 32'(bus.proc_tx_ready_out), 1);
   endtask
   initial begin
      bus.host_rx_data_in = '0;
      bus.host_rx_valid_in = 1'b0;
      bus.host_tx_ready_in = 1'b0;
      bus.proc_rx_rden_in = 1'b0;
      bus.proc_tx_data_in = '0;
      bus.proc_tx_wren_in = 1'b0;
      step();
      step();
      reset = 1'b0;
      check_idle("reset");
`ifdef SERIAL_BRIDGE_DROP_CNT_EN
      check("drop_reset", 32'(bus.drop_count_out), 0);
`endif
      // host pushes three bytes; head visible one cycle after first push
      bus.host_rx_valid_in = 1'b1;
      foreach (rx_q[i]) rx_q.delete(i);
      for (int i = 0; i < 3; i++) begin
         bus.host_rx_data_in = 8'h41 + 8'(i);
         rx_q.push_back(8'h41 + 8'(i));
         step();
         if (i == 0) begin
            check("rx_first_head", 32'(bus.proc_rx_data_out), 32'h41);
            check("rx_first_valid", 32'(bus.proc_rx_valid_out), 1);
         end
      end
      bus.host_rx_valid_in = 1'b0;
      check("rx_cnt3", 32'(bus.rx_count_out), 3);
      drain_rx();
      // TX overflow: ninth write dropped
      for (int i = 0; i < 9; i++) begin
         check("tx_ready_fill", 32'(bus.proc_tx_ready_out), (i < 8) ? 1 : 0);
         bus.proc_tx_wren_in = 1'b1;
         bus.proc_tx_data_in = 8'(i);
         if (i < 8) tx_q.push_back(8'(i));
         step();
      end
      bus.proc_tx_wren_in = 1'b0;
      check("tx_cnt_full", 32'(bus.tx_count_out), 8);
      check("tx_ready_full", 32'(bus.proc_tx_ready_out), 0);
      check("rx_untouched", 32'(bus.rx_count_out), 0);
`ifdef SERIAL_BRIDGE_DROP_CNT_EN
      check("drop_one", 32'(bus.drop_count_out), 1);
`endif
      drain_tx();
      // RX full with simultaneous push and pop: only the pop happens
      bus.host_rx_valid_in = 1'b1;
      for (int i = 0; i < 8; i++) begin
         bus.host_rx_data_in = 8'h10 + 8'(i);
         rx_q.push_back(8'h10 + 8'(i));
         step();
      end
      check("rx_cnt_full", 32'(bus.rx_count_out), 8);
      check("rx_ready_full", 32'(bus.host_rx_ready_out), 0);
      bus.host_rx_data_in = 8'h99;
      bus.proc_rx_rden_in = 1'b1;
      check("rx_full_head", 32'(bus.proc_rx_data_out), 32'(rx_q.pop_front()));
      step();
      bus.host_rx_valid_in = 1'b0;
      bus.proc_rx_rden_in = 1'b0;
      check("rx_cnt_7", 32'(bus.rx_count_out), 7);
      drain_rx();
      // RX empty with push and rden together: rden ignored
      bus.host_rx_valid_in = 1'b1;
      bus.host_rx_data_in = 8'h55;
      bus.proc_rx_rden_in = 1'b1;
      rx_q.push_back(8'h55);
      step();
      bus.host_rx_valid_in = 1'b0;
      bus.proc_rx_rden_in = 1'b0;
      check("rx_cnt_1", 32'(bus.rx_count_out), 1);
      check("rx_head_55", 32'(bus.proc_rx_data_out), 32'h55);
      drain_rx();
      // stream 20 bytes through TX with toggling host ready
      begin
         int sent = 0;
         int got = 0;
         int cyc = 0;
         while ((sent < 20 || tx_q.size() != 0) && cyc < 400) begin
            bus.host_tx_ready_in = cyc[0];
            bus.proc_tx_wren_in = (sent < 20) && bus.proc_tx_ready_out;
            bus.proc_tx_data_in = 8'h80 + 8'(sent);
            if (bus.host_tx_valid_out && bus.host_tx_ready_in) begin
               check("stream_data", 32'(bus.host_tx_data_out), 32'(tx_q.pop_front()));
               got++;
            end
            if (bus.proc_tx_wren_in) begin
               tx_q.push_back(8'h80 + 8'(sent));
               sent++;
            end
            step();
            cyc++;
         end
         bus.proc_tx_wren_in = 1'b0;
         bus.host_tx_ready_in = 1'b0;
         check("stream_count", got, 20);
      end
      // refill both FIFOs, then reset mid-stream with traffic on the inputs
      bus.proc_tx_wren_in = 1'b1;
      bus.host_rx_valid_in = 1'b1;
      for (int i = 0; i < 5; i++) begin
         bus.proc_tx_data_in = 8'hc0 + 8'(i);
         bus.host_rx_data_in = 8'hd0 + 8'(i);
         step();
      end
      check("pre_reset_tx_cnt", 32'(bus.tx_count_out), 5);
      check("pre_reset_rx_cnt", 32'(bus.rx_count_out), 5);
      bus.proc_rx_rden_in = 1'b1;
      bus.host_tx_ready_in = 1'b1;
      reset = 1'b1;
      step();
      reset = 1'b0;
      bus.proc_tx_wren_in = 1'b0;
      bus.host_rx_valid_in = 1'b0;
      bus.proc_rx_rden_in = 1'b0;
      bus.host_tx_ready_in = 1'b0;
      check_idle("midreset");
`ifdef SERIAL_BRIDGE_DROP_CNT_EN
      check("drop_midreset", 32'(bus.drop_count_out), 0);
`endif
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
